// File: rtl/jedro_1_wb_ctrl.sv
// Register-file write-back controller.
// Arbitrates between ALU results and buffered LSU load responses for the single
// register-file write port, and tracks registers with loads in flight so the
// decoder can stall on read-after-load hazards.
//
// Ports:
//   clk_i, rstn_i                     clock, async active-low reset
//   alu_valid_i/addr_i/data_i         ALU result, alu_ready_o accepts it
//   lsu_valid_i/addr_i/data_i         load response, lsu_ready_o accepts it into a 2-entry FIFO
//   issue_i, issue_addr_i             load dispatched to destination register
//   rs1_addr_i, rs2_addr_i, hazard_o  hazard query against pending loads (combinational)
//   wpc_addr_o/data_o/we_o            registered register-file write port
//   idle_o                            no buffered loads and no pending registers
module jedro_1_wb_ctrl #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned STARVE_MAX     = 4
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      alu_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0] alu_addr_i,
   input  logic [DATA_WIDTH-1:0]     alu_data_i,
   output logic                      alu_ready_o,
   input  logic                      lsu_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0] lsu_addr_i,
   input  logic [DATA_WIDTH-1:0]     lsu_data_i,
   output logic                      lsu_ready_o,
   input  logic                      issue_i,
   input  logic [REG_ADDR_WIDTH-1:0] issue_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
   output logic                      hazard_o,
   output logic [REG_ADDR_WIDTH-1:0] wpc_addr_o,
   output logic [DATA_WIDTH-1:0]     wpc_data_o,
   output logic                      wpc_we_o,
   output logic                      idle_o
);

   localparam int unsigned NUM_REGS = 2**REG_ADDR_WIDTH;
   localparam int unsigned CNT_W    = 2;
   localparam int unsigned STARVE_W = 4;

   // Load FIFO storage and bookkeeping
   logic [REG_ADDR_WIDTH-1:0] fifo_addr_q [2];
   logic [DATA_WIDTH-1:0]     fifo_data_q [2];
   logic                      wr_ptr_q, wr_ptr_d;
   logic                      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic [STARVE_W-1:0]       starve_q, starve_d;
   logic [NUM_REGS-1:0]       pend_q, pend_d;

   logic [REG_ADDR_WIDTH-1:0] wpc_addr_d;
   logic [DATA_WIDTH-1:0]     wpc_data_d;
   logic                      wpc_we_d;

   logic                      alu_fire;
   logic                      lsu_push;
   logic                      fifo_pop;
   logic                      fifo_empty;
   logic [REG_ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0]     head_data;

   // Handshakes depend only on registered state
   assign lsu_ready_o = (count_q < CNT_W'(2));
   assign alu_ready_o = (starve_q != STARVE_W'(STARVE_MAX));

   assign fifo_empty = (count_q == '0);
   assign alu_fire   = alu_valid_i & alu_ready_o;
   assign lsu_push   = lsu_valid_i & lsu_ready_o;
   // ALU has priority; a starved load wins because alu_ready_o drops
   assign fifo_pop   = ~alu_fire & ~fifo_empty;
   assign head_addr  = fifo_addr_q[rd_ptr_q];
   assign head_data  = fifo_data_q[rd_ptr_q];

   // pend_q[0] is never set, so x0 can never raise a hazard
   assign hazard_o = pend_q[rs1_addr_i] | pend_q[rs2_addr_i];
   assign idle_o   = fifo_empty & (pend_q == '0);

   // Next-state for FIFO, starvation counter, scoreboard and write port
   always_comb begin
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      starve_d   = starve_q;
      pend_d     = pend_q;
      wpc_we_d   = 1'b0;
      wpc_addr_d = wpc_addr_o;
      wpc_data_d = wpc_data_o;

      if (lsu_push) wr_ptr_d = ~wr_ptr_q;
      if (fifo_pop) rd_ptr_d = ~rd_ptr_q;

      case ({lsu_push, fifo_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // alu_fire implies starve_q < STARVE_MAX, so the increment saturates naturally
      if (fifo_empty || fifo_pop) begin
         starve_d = '0;
      end else if (alu_fire) begin
         starve_d = starve_q + STARVE_W'(1);
      end

      // Clear before set so a same-cycle issue to the popped register stays pending
      if (fifo_pop) pend_d[head_addr] = 1'b0;
      if (issue_i && (issue_addr_i != '0)) pend_d[issue_addr_i] = 1'b1;

      // Winners to x0 are consumed without asserting the write enable
      if (alu_fire) begin
         wpc_addr_d = alu_addr_i;
         wpc_data_d = alu_data_i;
         wpc_we_d   = (alu_addr_i != '0);
      end else if (fifo_pop) begin
         wpc_addr_d = head_addr;
         wpc_data_d = head_data;
         wpc_we_d   = (head_addr != '0);
      end
   end

   // Control and output state
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         count_q    <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         starve_q   <= '0;
         pend_q     <= '0;
         wpc_addr_o <= '0;
         wpc_data_o <= '0;
         wpc_we_o   <= 1'b0;
      end else begin
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         starve_q   <= starve_d;
         pend_q     <= pend_d;
         wpc_addr_o <= wpc_addr_d;
         wpc_data_o <= wpc_data_d;
         wpc_we_o   <= wpc_we_d;
      end
   end

   // FIFO payload; validity is tracked by count_q so no reset is needed
   always_ff @(posedge clk_i) begin
      if (lsu_push) begin
         fifo_addr_q[wr_ptr_q] <= lsu_addr_i;
         fifo_data_q[wr_ptr_q] <= lsu_data_i;
      end
   end

endmodule

// File: tb/tb_jedro_1_wb_ctrl.sv
module tb_jedro_1_wb_ctrl;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned SM = 4;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic          alu_valid_i;
   logic [AW-1:0] alu_addr_i;
   logic [DW-1:0] alu_data_i;
   logic          alu_ready_o;
   logic          lsu_valid_i;
   logic [AW-1:0] lsu_addr_i;
   logic [DW-1:0] lsu_data_i;
   logic          lsu_ready_o;
   logic          issue_i;
   logic [AW-1:0] issue_addr_i;
   logic [AW-1:0] rs1_addr_i;
   logic [AW-1:0] rs2_addr_i;
   logic          hazard_o;
   logic [AW-1:0] wpc_addr_o;
   logic [DW-1:0] wpc_data_o;
   logic          wpc_we_o;
   logic          idle_o;

   int n_checks = 0;
   int n_fail   = 0;

   jedro_1_wb_ctrl #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .STARVE_MAX(SM)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .alu_valid_i(alu_valid_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
      .alu_ready_o(alu_ready_o),
      .lsu_valid_i(lsu_valid_i), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
      .lsu_ready_o(lsu_ready_o),
      .issue_i(issue_i), .issue_addr_i(issue_addr_i),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .hazard_o(hazard_o),
      .wpc_addr_o(wpc_addr_o), .wpc_data_o(wpc_data_o), .wpc_we_o(wpc_we_o),
      .idle_o(idle_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid_i  = 1'b0; alu_addr_i = '0; alu_data_i = '0;
      lsu_valid_i  = 1'b0; lsu_addr_i = '0; lsu_data_i = '0;
      issue_i      = 1'b0; issue_addr_i = '0;
      rs1_addr_i   = '0;   rs2_addr_i = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rstn_i = 1'b0;
      tick();
      #2 rstn_i = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rstn_i = 1'b0;
      #3;
      n_checks++;
      if ({lsu_ready_o, alu_ready_o, hazard_o, idle_o, wpc_we_o} !== 5'b11010) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 11010",
            {lsu_ready_o, alu_ready_o, hazard_o, idle_o, wpc_we_o});
      end
      n_checks++;
      if (wpc_addr_o !== '0 || wpc_data_o !== '0) begin
         n_fail++; $display("FAIL reset_wpc: got %0h/%0h expected 0/0", wpc_addr_o, wpc_data_o);
      end
      tick();
      rstn_i = 1'b1;
      tick();
      n_checks++;
      if ({lsu_ready_o, alu_ready_o, hazard_o, idle_o, wpc_we_o} !== 5'b11010) begin
         n_fail++; $display("FAIL post_reset_flags: got %b expected 11010",
            {lsu_ready_o, alu_ready_o, hazard_o, idle_o, wpc_we_o});
      end
   endtask

   task automatic test_alu_only();
      do_reset();
      alu_valid_i = 1'b1; alu_addr_i = 5'd5; alu_data_i = 32'hDEADBEEF;
      tick();
      alu_valid_i = 1'b0;
      n_checks++;
      if (wpc_we_o !== 1'b1 || wpc_addr_o !== 5'd5 || wpc_data_o !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL alu_write: got we=%b a=%0d d=%h expected we=1 a=5 d=deadbeef",
            wpc_we_o, wpc_addr_o, wpc_data_o);
      end
      tick();
      n_checks++;
      if (wpc_we_o !== 1'b0 || wpc_addr_o !== 5'd5 || wpc_data_o !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL alu_hold: got we=%b a=%0d d=%h expected we=0 a=5 d=deadbeef",
            wpc_we_o, wpc_addr_o, wpc_data_o);
      end
   endtask

   task automatic test_load_path();
      do_reset();
      issue_i = 1'b1; issue_addr_i = 5'd7;
      tick();
      issue_i = 1'b0; rs1_addr_i = 5'd7;
      #1;
      n_checks++;
      if (hazard_o !== 1'b1 || idle_o !== 1'b0) begin
         n_fail++; $display("FAIL load_hazard_set: got hz=%b idle=%b expected hz=1 idle=0", hazard_o, idle_o);
      end
      lsu_valid_i = 1'b1; lsu_addr_i = 5'd7; lsu_data_i = 32'h1234;
      tick();
      lsu_valid_i = 1'b0;
      n_checks++;
      if (wpc_we_o !== 1'b0 || hazard_o !== 1'b1) begin
         n_fail++; $display("FAIL load_no_bypass: got we=%b hz=%b expected we=0 hz=1", wpc_we_o, hazard_o);
      end
      tick();
      n_checks++;
      if (wpc_we_o !== 1'b1 || wpc_addr_o !== 5'd7 || wpc_data_o !== 32'h1234) begin
         n_fail++; $display("FAIL load_write: got we=%b a=%0d d=%h expected we=1 a=7 d=1234",
            wpc_we_o, wpc_addr_o, wpc_data_o);
      end
      n_checks++;
      if (hazard_o !== 1'b0 || idle_o !== 1'b1) begin
         n_fail++; $display("FAIL load_clear: got hz=%b idle=%b expected hz=0 idle=1", hazard_o, idle_o);
      end
   endtask

   task automatic test_starvation();
      do_reset();
      lsu_valid_i = 1'b1; lsu_addr_i = 5'd9; lsu_data_i = 32'hAA;
      tick();
      lsu_valid_i = 1'b0;
      alu_valid_i = 1'b1; alu_addr_i = 5'd3;
      for (int i = 0; i < int'(SM); i++) begin
         alu_data_i = DW'(i + 100);
         #1;
         n_checks++;
         if (alu_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL starve_ready_%0d: got %b expected 1", i, alu_ready_o);
         end
         tick();
         n_checks++;
         if (wpc_we_o !== 1'b1 || wpc_addr_o !== 5'd3 || wpc_data_o !== DW'(i + 100)) begin
            n_fail++; $display("FAIL starve_alu_%0d: got we=%b a=%0d d=%0d expected we=1 a=3 d=%0d",
               i, wpc_we_o, wpc_addr_o, wpc_data_o, i + 100);
         end
      end
      alu_data_i = 32'd777;
      n_checks++;
      if (alu_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL starve_block: got %b expected 0", alu_ready_o);
      end
      tick();
      n_checks++;
      if (wpc_we_o !== 1'b1 || wpc_addr_o !== 5'd9 || wpc_data_o !== 32'hAA || alu_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL starve_load: got we=%b a=%0d d=%h rdy=%b expected we=1 a=9 d=aa rdy=1",
            wpc_we_o, wpc_addr_o, wpc_data_o, alu_ready_o);
      end
      tick();
      alu_valid_i = 1'b0;
      n_checks++;
      if (wpc_we_o !== 1'b1 || wpc_data_o !== 32'd777) begin
         n_fail++; $display("FAIL starve_resume: got we=%b d=%0d expected we=1 d=777", wpc_we_o, wpc_data_o);
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] exp_d [3];
      exp_d[0] = 32'hA0; exp_d[1] = 32'hB1; exp_d[2] = 32'hC2;
      do_reset();
      alu_valid_i = 1'b1; alu_addr_i = 5'd1; alu_data_i = 32'h11;
      lsu_valid_i = 1'b1; lsu_addr_i = 5'd10; lsu_data_i = exp_d[0];
      tick();
      lsu_addr_i = 5'd11; lsu_data_i = exp_d[1];
      tick();
      lsu_addr_i = 5'd12; lsu_data_i = exp_d[2];
      #1;
      n_checks++;
      if (lsu_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL bp_full: got %b expected 0", lsu_ready_o);
      end
      tick();
      n_checks++;
      if (lsu_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL bp_held: got %b expected 0", lsu_ready_o);
      end
      alu_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 1) lsu_valid_i = 1'b0;
         n_checks++;
         if (wpc_we_o !== 1'b1 || wpc_addr_o !== AW'(10 + i) || wpc_data_o !== exp_d[i]) begin
            n_fail++; $display("FAIL bp_order_%0d: got we=%b a=%0d d=%h expected we=1 a=%0d d=%h",
               i, wpc_we_o, wpc_addr_o, wpc_data_o, 10 + i, exp_d[i]);
         end
      end
      tick();
      n_checks++;
      if (wpc_we_o !== 1'b0 || idle_o !== 1'b1) begin
         n_fail++; $display("FAIL bp_drain: got we=%b idle=%b expected we=0 idle=1", wpc_we_o, idle_o);
      end
   endtask

   task automatic test_addr0();
      do_reset();
      alu_valid_i = 1'b1; alu_addr_i = '0; alu_data_i = 32'h5A5A;
      tick();
      alu_valid_i = 1'b0;
      n_checks++;
      if (wpc_we_o !== 1'b0) begin
         n_fail++; $display("FAIL x0_alu: got we=%b expected 0", wpc_we_o);
      end
      lsu_valid_i = 1'b1; lsu_addr_i = '0; lsu_data_i = 32'h77;
      tick();
      lsu_valid_i = 1'b0;
      tick();
      n_checks++;
      if (wpc_we_o !== 1'b0 || idle_o !== 1'b1) begin
         n_fail++; $display("FAIL x0_lsu: got we=%b idle=%b expected we=0 idle=1", wpc_we_o, idle_o);
      end
      issue_i = 1'b1; issue_addr_i = '0;
      tick();
      issue_i = 1'b0; rs1_addr_i = '0; rs2_addr_i = '0;
      #1;
      n_checks++;
      if (hazard_o !== 1'b0 || idle_o !== 1'b1) begin
         n_fail++; $display("FAIL x0_issue: got hz=%b idle=%b expected hz=0 idle=1", hazard_o, idle_o);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      alu_valid_i = 1'b1; alu_addr_i = 5'd2; alu_data_i = 32'h55;
      issue_i = 1'b1; issue_addr_i = 5'd4;
      lsu_valid_i = 1'b1; lsu_addr_i = 5'd4; lsu_data_i = 32'h1;
      tick();
      issue_addr_i = 5'd5; lsu_addr_i = 5'd5; lsu_data_i = 32'h2;
      tick();
      issue_addr_i = 5'd6; lsu_valid_i = 1'b0;
      tick();
      issue_i = 1'b0; rs1_addr_i = 5'd4; rs2_addr_i = 5'd6;
      #1;
      n_checks++;
      if (wpc_we_o !== 1'b1 || hazard_o !== 1'b1 || lsu_ready_o !== 1'b0 || idle_o !== 1'b0) begin
         n_fail++; $display("FAIL ar_setup: got we=%b hz=%b lrdy=%b idle=%b expected 1 1 0 0",
            wpc_we_o, hazard_o, lsu_ready_o, idle_o);
      end
      #1 rstn_i = 1'b0;
      #1;
      n_checks++;
      if ({wpc_we_o, hazard_o, idle_o, lsu_ready_o, alu_ready_o} !== 5'b00111 ||
          wpc_addr_o !== '0 || wpc_data_o !== '0) begin
         n_fail++; $display("FAIL ar_immediate: got flags=%b a=%0d d=%h expected flags=00111 a=0 d=0",
            {wpc_we_o, hazard_o, idle_o, lsu_ready_o, alu_ready_o}, wpc_addr_o, wpc_data_o);
      end
      alu_valid_i = 1'b0;
      tick();
      rstn_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (wpc_we_o !== 1'b0 || idle_o !== 1'b1 || hazard_o !== 1'b0) begin
            n_fail++; $display("FAIL ar_after_%0d: got we=%b idle=%b hz=%b expected 0 1 0",
               i, wpc_we_o, idle_o, hazard_o);
         end
      end
   endtask

   // Randomized traffic against a queue-based reference model
   task automatic test_random();
      logic [AW-1:0] qa [$];
      logic [DW-1:0] qd [$];
      logic [31:0]   m_pend;
      int            m_starve;
      bit            took, m_alu_rdy, m_lsu_rdy, fire, push, pop, exp_we;
      logic [AW-1:0] exp_a;
      logic [DW-1:0] exp_d;
      do_reset();
      m_pend = '0; m_starve = 0; took = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if (!alu_valid_i || took) begin
            alu_valid_i = ($urandom_range(0, 99) < 60);
            alu_addr_i  = AW'($urandom_range(0, 7));
            alu_data_i  = $urandom;
         end
         lsu_valid_i  = ($urandom_range(0, 99) < 45);
         lsu_addr_i   = AW'($urandom_range(0, 7));
         lsu_data_i   = $urandom;
         issue_i      = ($urandom_range(0, 99) < 25);
         issue_addr_i = AW'($urandom_range(0, 7));
         rs1_addr_i   = AW'($urandom_range(0, 7));
         rs2_addr_i   = AW'($urandom_range(0, 7));
         #1;
         m_alu_rdy = (m_starve != int'(SM));
         m_lsu_rdy = (qa.size() < 2);
         n_checks++;
         if (alu_ready_o !== m_alu_rdy || lsu_ready_o !== m_lsu_rdy) begin
            n_fail++; $display("FAIL rnd_ready_%0d: got alu=%b lsu=%b expected alu=%b lsu=%b",
               c, alu_ready_o, lsu_ready_o, m_alu_rdy, m_lsu_rdy);
         end
         n_checks++;
         if (hazard_o !== (m_pend[rs1_addr_i] | m_pend[rs2_addr_i]) ||
             idle_o !== (qa.size() == 0 && m_pend == 0)) begin
            n_fail++; $display("FAIL rnd_status_%0d: got hz=%b idle=%b expected hz=%b idle=%b", c,
               hazard_o, idle_o, m_pend[rs1_addr_i] | m_pend[rs2_addr_i], qa.size() == 0 && m_pend == 0);
         end
         fire = alu_valid_i && m_alu_rdy;
         push = lsu_valid_i && m_lsu_rdy;
         pop  = !fire && qa.size() != 0;
         exp_we = 1'b0; exp_a = '0; exp_d = '0;
         if (fire) begin
            exp_we = (alu_addr_i != 0); exp_a = alu_addr_i; exp_d = alu_data_i;
         end else if (pop) begin
            exp_we = (qa[0] != 0); exp_a = qa[0]; exp_d = qd[0];
         end
         if (qa.size() == 0 || pop) m_starve = 0;
         else if (fire && m_starve < int'(SM)) m_starve++;
         if (pop) begin
            m_pend[qa[0]] = 1'b0;
            void'(qa.pop_front());
            void'(qd.pop_front());
         end
         if (issue_i && issue_addr_i != 0) m_pend[issue_addr_i] = 1'b1;
         if (push) begin
            qa.push_back(lsu_addr_i);
            qd.push_back(lsu_data_i);
         end
         took = fire;
         tick();
         n_checks++;
         if (wpc_we_o !== exp_we || (exp_we && (wpc_addr_o !== exp_a || wpc_data_o !== exp_d))) begin
            n_fail++; $display("FAIL rnd_write_%0d: got we=%b a=%0d d=%h expected we=%b a=%0d d=%h",
               c, wpc_we_o, wpc_addr_o, wpc_data_o, exp_we, exp_a, exp_d);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_alu_only();
      test_load_path();
      test_starvation();
      test_backpressure();
      test_addr0();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
